// File: rtl/rob_commit_unit.sv
// rob_commit_unit: reorder buffer with single-entry in-order commit.
// Dispatch allocates at the tail, execute completes entries by index, and the
// head retires one completed entry per cycle. A retiring mispredicted branch
// flushes the whole buffer.
module rob_commit_unit #(
    parameter int NUM_ROB_ENTS = 64,
    parameter int NUM_PREGS    = 128,
    parameter int NUM_AREGS    = 32,
    localparam int IW = $clog2(NUM_ROB_ENTS),
    localparam int PW = $clog2(NUM_PREGS),
    localparam int AW = $clog2(NUM_AREGS)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          alloc_valid,
    output logic          alloc_ready,
    output logic [IW-1:0] alloc_index,
    input  logic          alloc_has_dst,
    input  logic [AW-1:0] alloc_dst_areg,
    input  logic [PW-1:0] alloc_dst_preg,
    input  logic [PW-1:0] alloc_old_preg,

    input  logic          cmpl_valid,
    input  logic [IW-1:0] cmpl_rob_index,
    input  logic          cmpl_br_mispred,

    output logic          ret_valid,
    output logic          ret_has_dst,
    output logic [AW-1:0] ret_dst_areg,
    output logic [PW-1:0] ret_dst_preg,
    output logic [PW-1:0] ret_free_preg,
    output logic          ret_flush,

    output logic [IW:0]   rob_count,
    output logic          rob_empty,
    output logic          rob_full
);

    localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [IW:0]   head_q;
    logic [IW:0]   tail_q;
    logic [IW-1:0] head_idx;
    logic [IW-1:0] tail_idx;

    // Per-entry control state.
    logic [NUM_ROB_ENTS-1:0] busy_q;
    logic [NUM_ROB_ENTS-1:0] done_q;
    logic [NUM_ROB_ENTS-1:0] mispred_q;

    // Per-entry payload; only meaningful while the entry is busy.
    logic          has_dst_q  [NUM_ROB_ENTS];
    logic [AW-1:0] areg_q     [NUM_ROB_ENTS];
    logic [PW-1:0] preg_q     [NUM_ROB_ENTS];
    logic [PW-1:0] old_preg_q [NUM_ROB_ENTS];

    logic head_busy;
    logic head_done;
    logic head_mispred;
    logic full_w;
    logic empty_w;
    logic alloc_fire;
    logic retire;
    logic flush;
    logic cmpl_accept;

    // Status, handshake and event decode, all from registered state except
    // the accept qualifiers on the allocate and complete requests.
    always_comb begin
        head_idx     = head_q[IW-1:0];
        tail_idx     = tail_q[IW-1:0];
        head_busy    = busy_q[head_idx];
        head_done    = done_q[head_idx];
        head_mispred = mispred_q[head_idx];

        full_w  = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
        empty_w = (head_q == tail_q);

        retire = head_busy && head_done;
        flush  = retire && head_mispred;

        // A mispredicted head blocks dispatch so nothing is allocated on the
        // edge that flushes the buffer.
        alloc_ready = !full_w && !(head_busy && head_done && head_mispred);
        alloc_index = tail_idx;
        alloc_fire  = alloc_valid && alloc_ready;

        // First completion wins; strays to idle entries and anything arriving
        // on a flush edge are dropped.
        cmpl_accept = cmpl_valid && busy_q[cmpl_rob_index]
                      && !done_q[cmpl_rob_index] && !flush;

        rob_count = tail_q - head_q;
        rob_empty = empty_w;
        rob_full  = full_w;
    end

    // Head/tail pointer update; a flush rewinds both to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (flush) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (retire)     head_q <= head_q + PTR_ONE;
            if (alloc_fire) tail_q <= tail_q + PTR_ONE;
        end
    end

    // Entry control bits. Allocate, complete and retire never target the
    // same entry on one edge: allocate needs an idle entry, complete needs a
    // busy not-done entry, retire needs a busy done entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            done_q    <= '0;
            mispred_q <= '0;
        end else if (flush) begin
            busy_q <= '0;
        end else begin
            if (retire) begin
                busy_q[head_idx] <= 1'b0;
            end
            if (alloc_fire) begin
                busy_q[tail_idx]    <= 1'b1;
                done_q[tail_idx]    <= 1'b0;
                mispred_q[tail_idx] <= 1'b0;
            end
            if (cmpl_accept) begin
                done_q[cmpl_rob_index]    <= 1'b1;
                mispred_q[cmpl_rob_index] <= cmpl_br_mispred;
            end
        end
    end

    // Payload write at the tail on allocation.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_dst_q[tail_idx]  <= alloc_has_dst;
            areg_q[tail_idx]     <= alloc_dst_areg;
            preg_q[tail_idx]     <= alloc_dst_preg;
            old_preg_q[tail_idx] <= alloc_old_preg;
        end
    end

    // Registered retire port: one-cycle pulse carrying the head entry, zero
    // otherwise.
    always_ff @(posedge clk) begin
        if (rst || !retire) begin
            ret_valid     <= 1'b0;
            ret_has_dst   <= 1'b0;
            ret_dst_areg  <= '0;
            ret_dst_preg  <= '0;
            ret_free_preg <= '0;
            ret_flush     <= 1'b0;
        end else begin
            ret_valid     <= 1'b1;
            ret_has_dst   <= has_dst_q[head_idx];
            ret_dst_areg  <= areg_q[head_idx];
            ret_dst_preg  <= preg_q[head_idx];
            ret_free_preg <= old_preg_q[head_idx];
            ret_flush     <= head_mispred;
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit: directed, table-driven checks of the reorder buffer
// plus hand-written sequences for full/wrap and mid-run reset.
module tb_rob_commit_unit;

    localparam int NE = 64;
    localparam int IW = 6;
    localparam int PW = 7;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [IW-1:0] alloc_index;
    logic          alloc_has_dst;
    logic [AW-1:0] alloc_dst_areg;
    logic [PW-1:0] alloc_dst_preg;
    logic [PW-1:0] alloc_old_preg;
    logic          cmpl_valid;
    logic [IW-1:0] cmpl_rob_index;
    logic          cmpl_br_mispred;
    logic          ret_valid;
    logic          ret_has_dst;
    logic [AW-1:0] ret_dst_areg;
    logic [PW-1:0] ret_dst_preg;
    logic [PW-1:0] ret_free_preg;
    logic          ret_flush;
    logic [IW:0]   rob_count;
    logic          rob_empty;
    logic          rob_full;

    int n_checks = 0;
    int n_fail   = 0;

    rob_commit_unit #(
        .NUM_ROB_ENTS(NE),
        .NUM_PREGS(128),
        .NUM_AREGS(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alloc_valid(alloc_valid),
        .alloc_ready(alloc_ready),
        .alloc_index(alloc_index),
        .alloc_has_dst(alloc_has_dst),
        .alloc_dst_areg(alloc_dst_areg),
        .alloc_dst_preg(alloc_dst_preg),
        .alloc_old_preg(alloc_old_preg),
        .cmpl_valid(cmpl_valid),
        .cmpl_rob_index(cmpl_rob_index),
        .cmpl_br_mispred(cmpl_br_mispred),
        .ret_valid(ret_valid),
        .ret_has_dst(ret_has_dst),
        .ret_dst_areg(ret_dst_areg),
        .ret_dst_preg(ret_dst_preg),
        .ret_free_preg(ret_free_preg),
        .ret_flush(ret_flush),
        .rob_count(rob_count),
        .rob_empty(rob_empty),
        .rob_full(rob_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic       hd;
        logic [4:0] ar;
        logic [6:0] pr;
        logic [6:0] op;
        logic       cv;
        logic [5:0] ci;
        logic       cm;
        logic       e_rv;
        logic       e_fl;
        logic [4:0] e_ar;
        logic [6:0] e_pr;
        logic [6:0] e_free;
        int         e_count;
        logic       e_ready;
        logic [5:0] e_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid     = 1'b0;
        alloc_has_dst   = 1'b0;
        alloc_dst_areg  = '0;
        alloc_dst_preg  = '0;
        alloc_old_preg  = '0;
        cmpl_valid      = 1'b0;
        cmpl_rob_index  = '0;
        cmpl_br_mispred = 1'b0;
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        idle_inputs();
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    function automatic vec_t alloc_v(input logic [4:0] ar, input logic [6:0] pr,
                                     input logic [6:0] op, input int cnt,
                                     input logic [5:0] idx);
        vec_t v;
        v = '{av: 1'b1, hd: 1'b1, ar: ar, pr: pr, op: op, cv: 1'b0, ci: '0, cm: 1'b0,
              e_rv: 1'b0, e_fl: 1'b0, e_ar: '0, e_pr: '0, e_free: '0,
              e_count: cnt, e_ready: 1'b1, e_idx: idx};
        return v;
    endfunction

    function automatic vec_t cmpl_v(input logic cv, input logic [5:0] ci, input logic cm,
                                    input logic av,
                                    input logic rv, input logic fl, input logic [4:0] ar,
                                    input logic [6:0] pr, input logic [6:0] fr,
                                    input int cnt, input logic rdy, input logic [5:0] idx);
        vec_t v;
        v = '{av: av, hd: 1'b0, ar: '0, pr: '0, op: '0, cv: cv, ci: ci, cm: cm,
              e_rv: rv, e_fl: fl, e_ar: ar, e_pr: pr, e_free: fr,
              e_count: cnt, e_ready: rdy, e_idx: idx};
        return v;
    endfunction

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            alloc_valid     = vecs[i].av;
            alloc_has_dst   = vecs[i].hd;
            alloc_dst_areg  = vecs[i].ar;
            alloc_dst_preg  = vecs[i].pr;
            alloc_old_preg  = vecs[i].op;
            cmpl_valid      = vecs[i].cv;
            cmpl_rob_index  = vecs[i].ci;
            cmpl_br_mispred = vecs[i].cm;
            step();
            chk($sformatf("%s[%0d].ret_valid", tag, i), int'(ret_valid), int'(vecs[i].e_rv));
            chk($sformatf("%s[%0d].ret_flush", tag, i), int'(ret_flush), int'(vecs[i].e_fl));
            chk($sformatf("%s[%0d].ret_dst_areg", tag, i), int'(ret_dst_areg), int'(vecs[i].e_ar));
            chk($sformatf("%s[%0d].ret_dst_preg", tag, i), int'(ret_dst_preg), int'(vecs[i].e_pr));
            chk($sformatf("%s[%0d].ret_free_preg", tag, i), int'(ret_free_preg), int'(vecs[i].e_free));
            chk($sformatf("%s[%0d].rob_count", tag, i), int'(rob_count), vecs[i].e_count);
            chk($sformatf("%s[%0d].alloc_ready", tag, i), int'(alloc_ready), int'(vecs[i].e_ready));
            chk($sformatf("%s[%0d].alloc_index", tag, i), int'(alloc_index), int'(vecs[i].e_idx));
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Reset state
        do_reset(2);
        chk("reset.rob_empty", int'(rob_empty), 1);
        chk("reset.rob_full", int'(rob_full), 0);
        chk("reset.alloc_ready", int'(alloc_ready), 1);
        chk("reset.alloc_index", int'(alloc_index), 0);
        chk("reset.ret_valid", int'(ret_valid), 0);
        chk("reset.ret_free_preg", int'(ret_free_preg), 0);
        chk("reset.rob_count", int'(rob_count), 0);

        // In-order retire despite reverse-order completion
        vecs.delete();
        vecs.push_back(alloc_v(5, 40, 10, 1, 1));
        vecs.push_back(alloc_v(6, 41, 11, 2, 2));
        vecs.push_back(alloc_v(7, 42, 12, 3, 3));
        vecs.push_back(cmpl_v(1, 2, 0, 0, 0, 0, 0, 0, 0, 3, 1, 3));
        vecs.push_back(cmpl_v(1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1, 3));
        vecs.push_back(cmpl_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 3));
        vecs.push_back(cmpl_v(0, 0, 0, 0, 1, 0, 5, 40, 10, 2, 1, 3));
        vecs.push_back(cmpl_v(0, 0, 0, 0, 1, 0, 6, 41, 11, 1, 1, 3));
        vecs.push_back(cmpl_v(0, 0, 0, 0, 1, 0, 7, 42, 12, 0, 1, 3));
        vecs.push_back(cmpl_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));
        run_table("inorder");

        // Mispredict flush, then stray and duplicate completions
        do_reset(1);
        vecs.delete();
        vecs.push_back(alloc_v(1, 50, 20, 1, 1));
        vecs.push_back(alloc_v(2, 51, 21, 2, 2));
        vecs.push_back(alloc_v(3, 52, 22, 3, 3));
        vecs.push_back(alloc_v(4, 53, 23, 4, 4));
        vecs.push_back(alloc_v(5, 54, 24, 5, 5));
        vecs.push_back(cmpl_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 5));
        // idx0 retires; idx1 becomes a done mispredicted head -> ready drops
        vecs.push_back(cmpl_v(1, 1, 1, 0, 1, 0, 1, 50, 20, 4, 0, 5));
        // flush edge: completion of 3 and the allocation attempt are dropped
        vecs.push_back(cmpl_v(1, 3, 0, 1, 1, 1, 2, 51, 21, 0, 1, 0));
        vecs.push_back(cmpl_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(cmpl_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // stray completion to an idle entry
        vecs.push_back(cmpl_v(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(alloc_v(9, 60, 30, 1, 1));
        vecs.push_back(cmpl_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        // duplicate with mispred=1 is ignored: no flush on the retire
        vecs.push_back(cmpl_v(1, 0, 1, 0, 1, 0, 9, 60, 30, 0, 1, 1));
        vecs.push_back(cmpl_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        run_table("flush");

        // Full and wrap
        do_reset(1);
        for (int i = 0; i < NE; i++) begin
            alloc_valid    = 1'b1;
            alloc_has_dst  = 1'b1;
            alloc_dst_areg = AW'(i % 32);
            alloc_dst_preg = PW'(i);
            alloc_old_preg = PW'(i + 64);
            step();
        end
        chk("full.rob_full", int'(rob_full), 1);
        chk("full.alloc_ready", int'(alloc_ready), 0);
        chk("full.rob_count", int'(rob_count), 64);
        chk("full.alloc_index", int'(alloc_index), 0);
        step();
        chk("full.ignored_alloc.count", int'(rob_count), 64);
        cmpl_valid     = 1'b1;
        cmpl_rob_index = '0;
        step();
        cmpl_valid = 1'b0;
        chk("full.cmpl_no_early_retire", int'(ret_valid), 0);
        chk("full.cmpl.count", int'(rob_count), 64);
        step();
        chk("full.retire.ret_valid", int'(ret_valid), 1);
        chk("full.retire.free_preg", int'(ret_free_preg), 64);
        chk("full.retire.count", int'(rob_count), 63);
        chk("full.retire.alloc_index", int'(alloc_index), 0);
        chk("full.retire.alloc_ready", int'(alloc_ready), 1);
        step();
        alloc_valid = 1'b0;
        chk("full.wrap.count", int'(rob_count), 64);
        chk("full.wrap.rob_full", int'(rob_full), 1);
        chk("full.wrap.alloc_index", int'(alloc_index), 1);
        chk("full.wrap.ret_valid", int'(ret_valid), 0);

        // Reset mid-run with the head entry done
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            alloc_valid    = 1'b1;
            alloc_dst_preg = PW'(i);
            alloc_old_preg = PW'(i + 80);
            step();
        end
        alloc_valid = 1'b0;
        for (int i = 5; i < 9; i++) begin
            cmpl_valid     = 1'b1;
            cmpl_rob_index = IW'(i);
            step();
        end
        cmpl_rob_index = '0;
        step();
        cmpl_valid = 1'b0;
        chk("midrst.pre.count", int'(rob_count), 20);
        chk("midrst.pre.ret_valid", int'(ret_valid), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst.ret_valid", int'(ret_valid), 0);
        chk("midrst.rob_count", int'(rob_count), 0);
        chk("midrst.rob_empty", int'(rob_empty), 1);
        chk("midrst.alloc_index", int'(alloc_index), 0);
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        chk("midrst.alloc.count", int'(rob_count), 1);
        chk("midrst.alloc.index", int'(alloc_index), 1);
        step();
        step();
        chk("midrst.no_stale_retire", int'(ret_valid), 0);
        chk("midrst.count_hold", int'(rob_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
